hack_cpu_mc: RTL and testbench

//  Multicycle, width-parametrised Hack CPU for systems where instruction ROM and data RAM have variable latency.

---
 rtl/hack_cpu_mc_if.sv | 29 ++
 rtl/hack_cpu_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_hack_cpu_mc.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_cpu_mc_if.sv
// Instruction-ROM and data-RAM request/ready bus of the multicycle Hack CPU.
interface hack_cpu_mc_if #(
    parameter int unsigned WIDTH = 16
);
    logic             INSTR_REQ;
    logic [WIDTH-1:0] INSTR_ADDR;
    logic [WIDTH-1:0] INSTR_DATA;
    logic             INSTR_READY;
    logic             DATA_RD;
    logic             DATA_WR;
    logic [WIDTH-1:0] DATA_ADDR;
    logic [WIDTH-1:0] DATA_WDATA;
    logic [WIDTH-1:0] DATA_RDATA;
    logic             DATA_READY;

    modport master (
        output INSTR_REQ, INSTR_ADDR,
        input  INSTR_DATA, INSTR_READY,
        output DATA_RD, DATA_WR, DATA_ADDR, DATA_WDATA,
        input  DATA_RDATA, DATA_READY
    );

    modport slave (
        input  INSTR_REQ, INSTR_ADDR,
        output INSTR_DATA, INSTR_READY,
        input  DATA_RD, DATA_WR, DATA_ADDR, DATA_WDATA,
        output DATA_RDATA, DATA_READY
    );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multicycle Hack CPU: fetch / decode / M-read / execute / M-write sequencer with
// REQ/READY memory handshakes, run/stop control, jump-to-self halt and retire pulse.
module hack_cpu_mc #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK_100MHz,
    input  logic             RESET_N,
    input  logic             ENABLE,
    hack_cpu_mc_if.master    bus,
    output logic [WIDTH-1:0] PC,
    output logic             HALTED,
    output logic             RETIRED,
    output logic [2:0]       STATE
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM_WR = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Hack ALU with control {zx,nx,zy,ny,f,no}; result packed as {zr, ng, out}
    function automatic logic [WIDTH+1:0] hack_alu(input logic [WIDTH-1:0] x_in,
                                                  input logic [WIDTH-1:0] y_in,
                                                  input logic [5:0]       ctl);
        logic [WIDTH-1:0] x_v;
        logic [WIDTH-1:0] y_v;
        logic [WIDTH-1:0] o_v;
        x_v = ctl[5] ? {WIDTH{1'b0}} : x_in;
        x_v = ctl[4] ? ~x_v : x_v;
        y_v = ctl[3] ? {WIDTH{1'b0}} : y_in;
        y_v = ctl[2] ? ~y_v : y_v;
        o_v = ctl[1] ? (x_v + y_v) : (x_v & y_v);
        o_v = ctl[0] ? ~o_v : o_v;
        return {(o_v == {WIDTH{1'b0}}), o_v[WIDTH-1], o_v};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] data_addr_q, data_addr_d;
    logic [WIDTH-1:0] data_wdata_q, data_wdata_d;
    logic             instr_req_q, instr_req_d;
    logic             data_rd_q, data_rd_d;
    logic             data_wr_q, data_wr_d;
    logic             halted_q, halted_d;
    logic             retired_q, retired_d;

    logic [WIDTH+1:0] alu_s;
    logic [WIDTH-1:0] alu_out_s;
    logic             zr_s;
    logic             ng_s;
    logic             jump_s;
    logic [WIDTH-1:0] pc_inc_s;

    // Datapath: ALU on pre-instruction D and A/M, jump decision, sequential PC
    always_comb begin
        alu_s     = hack_alu(d_q, ir_q[12] ? m_q : a_q, ir_q[11:6]);
        alu_out_s = alu_s[WIDTH-1:0];
        ng_s      = alu_s[WIDTH];
        zr_s      = alu_s[WIDTH+1];
        jump_s    = (ir_q[2] & ng_s) | (ir_q[1] & zr_s) | (ir_q[0] & ~ng_s & ~zr_s);
        pc_inc_s  = pc_q + ONE;
    end

    // Sequencer next-state and register updates
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        a_d          = a_q;
        d_d          = d_q;
        m_d          = m_q;
        ir_d         = ir_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        instr_req_d  = instr_req_q;
        data_rd_d    = data_rd_q;
        data_wr_d    = data_wr_q;
        halted_d     = halted_q;
        retired_d    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // A FETCH entered without a request (only after reset) may start one here
                if (instr_req_q) begin
                    if (bus.INSTR_READY) begin
                        ir_d        = bus.INSTR_DATA;
                        instr_req_d = 1'b0;
                        state_d     = S_DECODE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (ENABLE && !halted_q) begin
                    instr_req_d = 1'b1;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_DECODE: begin
                if (ir_q[WIDTH-1] && ir_q[12]) begin
                    data_addr_d = a_q;
                    data_rd_d   = 1'b1;
                    state_d     = S_MEM_RD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEM_RD: begin
                if (data_rd_q && bus.DATA_READY) begin
                    m_d       = bus.DATA_RDATA;
                    data_rd_d = 1'b0;
                    state_d   = S_EXEC;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_EXEC: begin
                if (!ir_q[WIDTH-1]) begin
                    a_d  = {1'b0, ir_q[WIDTH-2:0]};
                    pc_d = pc_inc_s;
                end else begin
                    a_d  = ir_q[5] ? alu_out_s : a_q;
                    d_d  = ir_q[4] ? alu_out_s : d_q;
                    pc_d = jump_s ? a_q : pc_inc_s;
                    if (jump_s && (ir_q[2:0] == 3'b111) && (a_q == pc_q)) begin
                        halted_d = 1'b1;
                    end else begin
                        halted_d = halted_q;
                    end
                end
                if (ir_q[WIDTH-1] && ir_q[3]) begin
                    data_addr_d  = a_q;
                    data_wdata_d = alu_out_s;
                    data_wr_d    = 1'b1;
                    state_d      = S_MEM_WR;
                end else begin
                    retired_d   = 1'b1;
                    instr_req_d = ENABLE & ~halted_d;
                    state_d     = S_FETCH;
                end
            end
            S_MEM_WR: begin
                if (data_wr_q && bus.DATA_READY) begin
                    data_wr_d   = 1'b0;
                    retired_d   = 1'b1;
                    instr_req_d = ENABLE & ~halted_q;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_STOP: begin
                if (ENABLE && !halted_q) begin
                    instr_req_d = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                instr_req_d = 1'b0;
                data_rd_d   = 1'b0;
                data_wr_d   = 1'b0;
                state_d     = S_FETCH;
            end
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge CLK_100MHz) begin
        if (!RESET_N) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_VECTOR;
            a_q          <= {WIDTH{1'b0}};
            d_q          <= {WIDTH{1'b0}};
            m_q          <= {WIDTH{1'b0}};
            ir_q         <= {WIDTH{1'b0}};
            data_addr_q  <= {WIDTH{1'b0}};
            data_wdata_q <= {WIDTH{1'b0}};
            instr_req_q  <= 1'b0;
            data_rd_q    <= 1'b0;
            data_wr_q    <= 1'b0;
            halted_q     <= 1'b0;
            retired_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            a_q          <= a_d;
            d_q          <= d_d;
            m_q          <= m_d;
            ir_q         <= ir_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            instr_req_q  <= instr_req_d;
            data_rd_q    <= data_rd_d;
            data_wr_q    <= data_wr_d;
            halted_q     <= halted_d;
            retired_q    <= retired_d;
        end
    end

    assign bus.INSTR_REQ  = instr_req_q;
    assign bus.INSTR_ADDR = pc_q;
    assign bus.DATA_RD    = data_rd_q;
    assign bus.DATA_WR    = data_wr_q;
    assign bus.DATA_ADDR  = data_addr_q;
    assign bus.DATA_WDATA = data_wdata_q;
    assign PC             = pc_q;
    assign HALTED         = halted_q;
    assign RETIRED        = retired_q;
    assign STATE          = state_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: small ROM/RAM responder with configurable wait states.
module tb_hack_cpu_mc;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] pc;
    logic        halted;
    logic        retired;
    logic [2:0]  state;

    hack_cpu_mc_if #(.WIDTH(16)) bus ();

    hack_cpu_mc #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .CLK_100MHz (clk),
        .RESET_N    (rst_n),
        .ENABLE     (enable),
        .bus        (bus),
        .PC         (pc),
        .HALTED     (halted),
        .RETIRED    (retired),
        .STATE      (state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 0;
    int ret_cnt, ireq_cnt, wr_cnt, stab_err, icnt, dcnt;
    logic [15:0] wr_addr, wr_data, iaddr, daddr, dwdata;
    logic [15:0] rom [0:31];
    logic [15:0] ram [0:31];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: READY after 'lat' wait cycles; logs writes and protocol slips
    initial begin
        bus.INSTR_READY = 1'b0;
        bus.INSTR_DATA  = 16'h0000;
        bus.DATA_READY  = 1'b0;
        bus.DATA_RDATA  = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                icnt = 0; dcnt = 0; ret_cnt = 0; ireq_cnt = 0; wr_cnt = 0; stab_err = 0;
                wr_addr = 16'h0000; wr_data = 16'h0000;
                bus.INSTR_READY = 1'b0;
                bus.DATA_READY  = 1'b0;
            end else begin
                if (retired === 1'b1) ret_cnt++;
                if (bus.INSTR_REQ === 1'b1) begin
                    ireq_cnt++;
                    if (bus.INSTR_READY === 1'b1) stab_err++;
                    if (icnt > 0 && bus.INSTR_ADDR !== iaddr) stab_err++;
                    iaddr = bus.INSTR_ADDR;
                    bus.INSTR_DATA  = rom[bus.INSTR_ADDR[4:0]];
                    bus.INSTR_READY = (icnt >= lat) ? 1'b1 : 1'b0;
                    icnt++;
                end else begin
                    if (icnt > 0 && bus.INSTR_READY !== 1'b1) stab_err++;
                    icnt = 0;
                    bus.INSTR_READY = 1'b0;
                end
                if (bus.DATA_RD === 1'b1 || bus.DATA_WR === 1'b1) begin
                    if (bus.DATA_RD === 1'b1 && bus.DATA_WR === 1'b1) stab_err++;
                    if (bus.DATA_READY === 1'b1) stab_err++;
                    if (dcnt > 0 && (bus.DATA_ADDR !== daddr || bus.DATA_WDATA !== dwdata)) stab_err++;
                    daddr  = bus.DATA_ADDR;
                    dwdata = bus.DATA_WDATA;
                    bus.DATA_RDATA = ram[bus.DATA_ADDR[4:0]];
                    bus.DATA_READY = (dcnt >= lat) ? 1'b1 : 1'b0;
                    if (dcnt >= lat && bus.DATA_WR === 1'b1) begin
                        wr_cnt++;
                        wr_addr = bus.DATA_ADDR;
                        wr_data = bus.DATA_WDATA;
                    end
                    dcnt++;
                end else begin
                    if (dcnt > 0 && bus.DATA_READY !== 1'b1) stab_err++;
                    dcnt = 0;
                    bus.DATA_READY = 1'b0;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
    endtask

    task automatic do_reset(input int wait_lat);
        rst_n  = 1'b0;
        enable = 1'b1;
        lat    = wait_lat;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_retired(input int target, input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            @(negedge clk); #1;
            cycles++;
            if (ret_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.INSTR_REQ, bus.DATA_RD, bus.DATA_WR, halted, retired} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 00000", {bus.INSTR_REQ, bus.DATA_RD, bus.DATA_WR, halted, retired});
        end
        n_cmp++;
        if ({pc, state, bus.DATA_ADDR, bus.DATA_WDATA} !== {16'h0000, 3'd0, 16'h0000, 16'h0000}) begin
            n_bad++; $display("FAIL reset_regs: got pc=%h st=%0d da=%h wd=%h expected zeros", pc, state, bus.DATA_ADDR, bus.DATA_WDATA);
        end
    endtask

    task automatic test_program(input int wait_lat, input int exp_cycles);
        int cyc; bit ok;
        clear_mem();
        rom[0] = 16'h0015; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
        do_reset(wait_lat);
        wait_retired(4, 200, cyc, ok);
        n_cmp++;
        if (!ok || cyc !== exp_cycles) begin
            n_bad++; $display("FAIL prog_lat%0d_cycles: got %0d (done=%0d) expected %0d", wait_lat, cyc, ok, exp_cycles);
        end
        n_cmp++;
        if (wr_cnt !== 1 || wr_addr !== 16'd7 || wr_data !== 16'd21) begin
            n_bad++; $display("FAIL prog_lat%0d_write: got n=%0d @%0d=%0d expected n=1 @7=21", wait_lat, wr_cnt, wr_addr, wr_data);
        end
        n_cmp++;
        if (dut.a_q !== 16'd7 || dut.d_q !== 16'd21) begin
            n_bad++; $display("FAIL prog_lat%0d_regs: got A=%0d D=%0d expected A=7 D=21", wait_lat, dut.a_q, dut.d_q);
        end
        n_cmp++;
        if (stab_err !== 0) begin
            n_bad++; $display("FAIL prog_lat%0d_handshake: got %0d violations expected 0", wait_lat, stab_err);
        end
    endtask

    task automatic test_mem_rmw();
        int cyc; bit ok;
        clear_mem();
        rom[0] = 16'h0005; rom[1] = 16'hFDE8;
        ram[5] = 16'd9;
        do_reset(0);
        wait_retired(2, 100, cyc, ok);
        n_cmp++;
        if (!ok || cyc !== 9) begin
            n_bad++; $display("FAIL rmw_cycles: got %0d (done=%0d) expected 9", cyc, ok);
        end
        n_cmp++;
        if (wr_cnt !== 1 || wr_addr !== 16'd5 || wr_data !== 16'd10) begin
            n_bad++; $display("FAIL rmw_write: got n=%0d @%0d=%0d expected n=1 @5=10", wr_cnt, wr_addr, wr_data);
        end
        n_cmp++;
        if (dut.a_q !== 16'd10 || dut.d_q !== 16'd0) begin
            n_bad++; $display("FAIL rmw_regs: got A=%0d D=%0d expected A=10 D=0", dut.a_q, dut.d_q);
        end
    endtask

    task automatic test_jumps();
        logic [15:0] dset [0:6];
        logic [15:0] jins [0:6];
        logic [15:0] expc [0:6];
        int cyc; bit ok;
        dset = '{16'hEE90, 16'hEA90, 16'hEA90, 16'hEE90, 16'hEA90, 16'hEE90, 16'hEFD0};
        jins = '{16'hE304, 16'hE304, 16'hE302, 16'hE302, 16'hE303, 16'hE303, 16'hE301};
        expc = '{16'd12, 16'd3, 16'd12, 16'd3, 16'd12, 16'd3, 16'd12};
        for (int k = 0; k < 7; k++) begin
            clear_mem();
            rom[0] = dset[k]; rom[1] = 16'h000C; rom[2] = jins[k];
            do_reset(0);
            wait_retired(3, 100, cyc, ok);
            n_cmp++;
            if (!ok || pc !== expc[k] || halted !== 1'b0) begin
                n_bad++; $display("FAIL jump_%0d: got pc=%0d halted=%b (done=%0d) expected pc=%0d halted=0", k, pc, halted, ok, expc[k]);
            end
        end
    endtask

    task automatic test_halt();
        int cyc; int req_snap;
        clear_mem();
        rom[0] = 16'h0009; rom[1] = 16'h0009; rom[2] = 16'h0003; rom[3] = 16'hEA87;
        do_reset(0);
        cyc = 0;
        while (cyc < 100 && halted !== 1'b1) begin
            @(negedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (halted !== 1'b1 || pc !== 16'd3 || ret_cnt !== 4) begin
            n_bad++; $display("FAIL halt_set: got halted=%b pc=%0d retired=%0d expected 1/3/4", halted, pc, ret_cnt);
        end
        req_snap = ireq_cnt;
        repeat (20) @(negedge clk);
        #1;
        n_cmp++;
        if (ireq_cnt !== req_snap || state !== 3'd5 || halted !== 1'b1) begin
            n_bad++; $display("FAIL halt_idle: got reqs=%0d state=%0d halted=%b expected reqs=%0d state=5 halted=1", ireq_cnt, state, halted, req_snap);
        end
        do_reset(0);
        @(negedge clk); #1;
        n_cmp++;
        if (halted !== 1'b0) begin
            n_bad++; $display("FAIL halt_clear: got %b expected 0", halted);
        end
        cyc = 0;
        while (cyc < 20 && bus.INSTR_REQ !== 1'b1) begin
            @(negedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (bus.INSTR_REQ !== 1'b1 || bus.INSTR_ADDR !== 16'h0000) begin
            n_bad++; $display("FAIL halt_refetch: got req=%b addr=%h expected req=1 addr=0000", bus.INSTR_REQ, bus.INSTR_ADDR);
        end
    endtask

    task automatic test_reset_mid_read();
        int cyc;
        clear_mem();
        rom[0] = 16'h0015; rom[1] = 16'hEC10; rom[2] = 16'h0005; rom[3] = 16'hFC10;
        ram[5] = 16'h1234;
        do_reset(5);
        cyc = 0;
        while (cyc < 200 && bus.DATA_RD !== 1'b1) begin
            @(negedge clk); #1;
            cyc++;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.DATA_RD !== 1'b1 || dut.d_q !== 16'd21 || bus.DATA_ADDR !== 16'd5) begin
            n_bad++; $display("FAIL rdwait_state: got rd=%b D=%0d addr=%0d expected rd=1 D=21 addr=5", bus.DATA_RD, dut.d_q, bus.DATA_ADDR);
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.DATA_RD !== 1'b0 || pc !== 16'd0 || dut.a_q !== 16'd0 || dut.d_q !== 16'd0 || state !== 3'd0) begin
            n_bad++; $display("FAIL rdwait_reset: got rd=%b pc=%0d A=%0d D=%0d st=%0d expected all 0", bus.DATA_RD, pc, dut.a_q, dut.d_q, state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_enable_stop();
        int cyc; bit ok;
        clear_mem();
        rom[0] = 16'h0021; rom[1] = 16'hEC10; rom[2] = 16'h0008; rom[3] = 16'hE308; rom[4] = 16'h0001;
        do_reset(3);
        cyc = 0;
        while (cyc < 200 && bus.DATA_WR !== 1'b1) begin
            @(negedge clk); #1;
            cyc++;
        end
        enable = 1'b0;
        cyc = 0;
        while (cyc < 40 && state !== 3'd5) begin
            @(negedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (state !== 3'd5 || bus.INSTR_REQ !== 1'b0 || pc !== 16'd4 || ret_cnt !== 4) begin
            n_bad++; $display("FAIL stop_state: got st=%0d req=%b pc=%0d retired=%0d expected 5/0/4/4", state, bus.INSTR_REQ, pc, ret_cnt);
        end
        n_cmp++;
        if (wr_cnt !== 1 || wr_addr !== 16'd8 || wr_data !== 16'd33) begin
            n_bad++; $display("FAIL stop_write: got n=%0d @%0d=%0d expected n=1 @8=33", wr_cnt, wr_addr, wr_data);
        end
        enable = 1'b1;
        wait_retired(5, 100, cyc, ok);
        n_cmp++;
        if (!ok || dut.a_q !== 16'd1 || stab_err !== 0) begin
            n_bad++; $display("FAIL stop_resume: got done=%0d A=%0d slips=%0d expected done=1 A=1 slips=0", ok, dut.a_q, stab_err);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        test_reset();
        test_program(0, 14);
        test_program(3, 29);
        test_mem_rmw();
        test_jumps();
        test_halt();
        test_reset_mid_read();
        test_enable_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
